// File: rtl/mcpu_gen_if.sv
// Memory-side bus of the mcpu_gen core: single-port read/write memory with a ready handshake.
// The core drives the master modport; a memory model or arbiter drives the slave modport.
interface mcpu_gen_if #(
    parameter int unsigned DW = 8
);
    localparam int unsigned AW = DW - 2;

    logic          mem_rdy;
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          re;
    logic          we;
    logic          halted;

    modport master (
        input  mem_rdy,
        input  din,
        output addr,
        output dout,
        output re,
        output we,
        output halted
    );

    modport slave (
        output mem_rdy,
        output din,
        input  addr,
        input  dout,
        input  re,
        input  we,
        input  halted
    );
endinterface

// File: rtl/mcpu_gen.sv
// Minimal accumulator CPU (NOR/ADD/STA/JCC) with a ready-stretched memory bus.
// Optional HALT-on-self-jump behaviour is enabled by defining MCPU_GEN_HALT_EN.
module mcpu_gen #(
    parameter int unsigned DW = 8
) (
    input  logic        clk,
    input  logic        rst,
    mcpu_gen_if.master  bus
);
    localparam int unsigned AW = DW - 2;

    localparam logic [1:0] OpNor = 2'b00;
    localparam logic [1:0] OpAdd = 2'b01;
    localparam logic [1:0] OpSta = 2'b10;
    localparam logic [1:0] OpJcc = 2'b11;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StJnt   = 2'd2
`ifdef MCPU_GEN_HALT_EN
        ,
        StHalt  = 2'd3
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] adreg_q, adreg_d;
    logic [1:0]    op_q, op_d;

    logic          re_c;
    logic          we_c;
    logic [DW:0]   sum;
    logic [1:0]    din_op;
    logic [AW-1:0] din_opnd;

    assign sum      = {1'b0, acc_q} + {1'b0, bus.din};
    assign din_op   = bus.din[DW-1:DW-2];
    assign din_opnd = bus.din[AW-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
            acc_q   <= '0;
            carry_q <= 1'b0;
            pc_q    <= '0;
            adreg_q <= '0;
            op_q    <= OpNor;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            pc_q    <= pc_d;
            adreg_q <= adreg_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        pc_d    = pc_q;
        adreg_d = adreg_q;
        op_d    = op_q;
        re_c    = 1'b0;
        we_c    = 1'b0;

        unique case (state_q)
            StFetch: begin
                re_c = 1'b1;
                if (bus.mem_rdy) begin
                    pc_d    = adreg_q + AW'(1);
                    adreg_d = din_opnd;
                    op_d    = din_op;
                    if (din_op != OpJcc) begin
                        state_d = StExec;
                    end else if (carry_q) begin
                        state_d = StJnt;
`ifdef MCPU_GEN_HALT_EN
                    end else if (din_opnd == adreg_q) begin
                        state_d = StHalt;
`endif
                    end else begin
                        // Taken jump: the target is already in adreg, fetch it next.
                        state_d = StFetch;
                    end
                end
            end
            StExec: begin
                re_c = (op_q == OpNor) || (op_q == OpAdd);
                we_c = (op_q == OpSta);
                if (bus.mem_rdy) begin
                    unique case (op_q)
                        OpNor:   acc_d = ~(acc_q | bus.din);
                        OpAdd:   {carry_d, acc_d} = sum;
                        default: ;
                    endcase
                    adreg_d = pc_q;
                    state_d = StFetch;
                end
            end
            StJnt: begin
                // Not-taken jump consumes the carry and resumes at the fall-through pc.
                carry_d = 1'b0;
                adreg_d = pc_q;
                state_d = StFetch;
            end
`ifdef MCPU_GEN_HALT_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Strobes and address are forced quiet while reset is held, before the first reset edge.
    assign bus.addr = rst ? adreg_q : '0;
    assign bus.re   = rst & re_c;
    assign bus.we   = rst & we_c;
    assign bus.dout = acc_q;

`ifdef MCPU_GEN_HALT_EN
    assign bus.halted = rst && (state_q == StHalt);
`else
    assign bus.halted = 1'b0;
`endif

    a_strobe_excl: assert property (@(posedge clk) !(bus.re && bus.we));
    a_halt_quiet:  assert property (@(posedge clk) bus.halted |-> !(bus.re || bus.we));

endmodule

// File: tb/tb_mcpu_gen.sv
// Self-checking bench for mcpu_gen (DW=8): table vectors, directed corner sequences and a
// randomized run against an instruction-level reference model producing the expected bus trace.
module tb_mcpu_gen;
    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = DW - 2;
    localparam int unsigned MEM = 1 << AW;
`ifdef MCPU_GEN_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mcpu_gen_if #(.DW(DW)) bus ();

    mcpu_gen #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] tb_mem [MEM];
    assign bus.din = tb_mem[bus.addr];

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    // Expected bus state for one cycle (or one stretched memory cycle).
    typedef struct packed {
        logic          re;
        logic          we;
        logic          halted;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout;
    } bus_t;

    typedef struct {
        logic [DW-1:0] a0;
        logic [1:0]    op;
        logic [DW-1:0] m;
        logic [DW-1:0] exp_acc;
        logic          exp_c;
    } vec_t;

    // Reference model state (instruction level)
    logic [DW-1:0] m_mem [MEM];
    logic [DW-1:0] m_acc;
    logic          m_carry;
    logic [AW-1:0] m_nf;
    logic          m_halted;
    bus_t          exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic rdy);
        bus.mem_rdy = rdy;
        if (rdy && bus.we && rst) begin
            tb_mem[bus.addr] = bus.dout;
            wr_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b1;
        bus.mem_rdy = 1'b1;
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < int'(MEM); i++) tb_mem[i] = '0;
    endtask

    task automatic model_step();
        bus_t          it;
        logic [AW-1:0] f;
        logic [DW-1:0] ins;
        logic [AW-1:0] opnd;
        logic [AW-1:0] pc;
        if (m_halted) begin
            exp_q.push_back(bus_t'{re: 1'b0, we: 1'b0, halted: 1'b1, addr: m_nf, dout: m_acc});
            return;
        end
        f    = m_nf;
        ins  = m_mem[f];
        opnd = ins[AW-1:0];
        pc   = f + 1'b1;
        exp_q.push_back(bus_t'{re: 1'b1, we: 1'b0, halted: 1'b0, addr: f, dout: m_acc});
        case (ins[DW-1:DW-2])
            2'b00: begin
                it = bus_t'{re: 1'b1, we: 1'b0, halted: 1'b0, addr: opnd, dout: m_acc};
                exp_q.push_back(it);
                m_acc = ~(m_acc | m_mem[opnd]);
                m_nf  = pc;
            end
            2'b01: begin
                it = bus_t'{re: 1'b1, we: 1'b0, halted: 1'b0, addr: opnd, dout: m_acc};
                exp_q.push_back(it);
                {m_carry, m_acc} = {1'b0, m_acc} + {1'b0, m_mem[opnd]};
                m_nf = pc;
            end
            2'b10: begin
                it = bus_t'{re: 1'b0, we: 1'b1, halted: 1'b0, addr: opnd, dout: m_acc};
                exp_q.push_back(it);
                m_mem[opnd] = m_acc;
                m_nf = pc;
            end
            default: begin
                if (m_carry) begin
                    it = bus_t'{re: 1'b0, we: 1'b0, halted: 1'b0, addr: opnd, dout: m_acc};
                    exp_q.push_back(it);
                    m_carry = 1'b0;
                    m_nf    = pc;
                end else if (HaltEn && opnd == f) begin
                    m_halted = 1'b1;
                    m_nf     = opnd;
                end else begin
                    m_nf = opnd;
                end
            end
        endcase
    endtask

    task automatic run_random(input int ncyc);
        bus_t h;
        bus_t act;
        logic rdy;
        for (int i = 0; i < int'(MEM); i++) begin
            tb_mem[i] = DW'($urandom_range(0, (1 << DW) - 1));
            m_mem[i]  = tb_mem[i];
        end
        m_acc = '0; m_carry = 1'b0; m_nf = '0; m_halted = 1'b0;
        exp_q.delete();
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            while (exp_q.size() == 0) model_step();
            h   = exp_q[0];
            act = {bus.re, bus.we, bus.halted, bus.addr, bus.dout};
            chk("random_bus", 32'(act), 32'(h));
            rdy = ($urandom_range(0, 3) != 0);
            if (!h.re && !h.we) begin
                if (!h.halted) void'(exp_q.pop_front());
            end else if (rdy) begin
                void'(exp_q.pop_front());
            end
            tick(rdy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt [7];
        vt[0] = '{a0: 8'hF0, op: 2'b01, m: 8'h20, exp_acc: 8'h10, exp_c: 1'b1};
        vt[1] = '{a0: 8'h0F, op: 2'b00, m: 8'h30, exp_acc: 8'hC0, exp_c: 1'b0};
        vt[2] = '{a0: 8'h01, op: 2'b01, m: 8'hFF, exp_acc: 8'h00, exp_c: 1'b1};
        vt[3] = '{a0: 8'h7F, op: 2'b01, m: 8'h01, exp_acc: 8'h80, exp_c: 1'b0};
        vt[4] = '{a0: 8'h00, op: 2'b00, m: 8'h00, exp_acc: 8'hFF, exp_c: 1'b0};
        vt[5] = '{a0: 8'hAA, op: 2'b10, m: 8'h55, exp_acc: 8'hAA, exp_c: 1'b0};
        vt[6] = '{a0: 8'hFF, op: 2'b01, m: 8'hFF, exp_acc: 8'hFE, exp_c: 1'b1};

        bus.mem_rdy = 1'b0;
        clear_mem();
        @(negedge clk);
        #1;

        // Reset behaviour and first fetch
        rst = 1'b0;
        tick(1'b0);
        tick(1'b1);
        chk("rst_re", 32'(bus.re), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        rst = 1'b1;
        #1;
        chk("first_fetch", 32'({bus.re, bus.we, bus.addr, bus.dout}), 32'({2'b10, 6'h00, 8'h00}));

        // Table: load acc, run one op, observe acc and carry through a JCC
        foreach (vt[v]) begin
            clear_mem();
            tb_mem[0]     = 8'h3E;
            tb_mem[6'h3E] = ~vt[v].a0;
            tb_mem[1]     = {vt[v].op, 6'h3D};
            tb_mem[6'h3D] = vt[v].m;
            tb_mem[2]     = 8'hC4;
            tb_mem[3]     = 8'hC4;
            tb_mem[4]     = 8'hC4;
            do_reset();
            for (int k = 0; k < 4; k++) tick(1'b1);
            chk($sformatf("vec%0d_acc", v), 32'(bus.dout), 32'(vt[v].exp_acc));
            tick(1'b1);
            chk($sformatf("vec%0d_carry_re", v), 32'({bus.re, bus.we}), 32'({~vt[v].exp_c, 1'b0}));
            tick(1'b1);
            chk($sformatf("vec%0d_next_addr", v), 32'(bus.addr),
                vt[v].exp_c ? 32'd3 : 32'd4);
            tick(1'b1);
            chk($sformatf("vec%0d_carry_clr", v), 32'(bus.re),
                32'(vt[v].exp_c ? 1'b1 : !HaltEn));
        end

        // STA at 0x3F stretched by three wait cycles; pc wraps to 0
        clear_mem();
        tb_mem[0]     = 8'h3E;
        tb_mem[6'h3E] = 8'hA5;
        tb_mem[1]     = 8'hFF;
        tb_mem[6'h3F] = 8'hBF;
        do_reset();
        wr_cnt = 0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        chk("jcc_taken_addr", 32'({bus.re, bus.addr}), 32'({1'b1, 6'h3F}));
        tick(1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sta_wait%0d", k), 32'({bus.re, bus.we, bus.addr, bus.dout}),
                32'({2'b01, 6'h3F, 8'h5A}));
            tick(k == 3);
        end
        chk("pc_wrap", 32'({bus.re, bus.we, bus.addr}), 32'({2'b10, 6'h00}));
        chk("sta_writes", 32'(wr_cnt), 32'd1);
        chk("sta_data", 32'(tb_mem[6'h3F]), 32'h5A);

        // Self-jump with carry clear, then reset during a pending wait
        clear_mem();
        tb_mem[0]     = 8'h3E;
        tb_mem[6'h3E] = 8'hA5;
        tb_mem[1]     = 8'hC1;
        do_reset();
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        chk("selfjmp_1", 32'({bus.re, bus.halted, bus.addr}),
            32'({!HaltEn, HaltEn, 6'h01}));
        tick(1'b1);
        chk("selfjmp_2", 32'({bus.re, bus.halted, bus.addr}),
            32'({!HaltEn, HaltEn, 6'h01}));
        tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        chk("midwait_rst", 32'({bus.re, bus.we, bus.halted, bus.addr}), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_fetch", 32'({bus.re, bus.we, bus.halted, bus.addr, bus.dout}),
            32'({3'b100, 6'h00, 8'h00}));

        // Randomized programs against the reference model
        for (int r = 0; r < 10; r++) run_random(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mcpu_gen.md
MCPU_GEN -- requirements
Module: mcpu_gen

Interface
REQ-001 Parameter: DW, 8, data/instruction width in bits; legal range 6..16.
REQ-002 Parameter: AW, DW-2, address width; derived, not overridable.
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: mem_rdy  input  1  memory ready; completes current memory cycle when 1.
REQ-006 Port: din  input  DW  read data / instruction from memory.
REQ-007 Port: addr  output  AW  memory address, driven from address register every cycle.
REQ-008 Port: dout  output  DW  write data, always equals acc[DW-1:0].
REQ-009 Port: re  output  1  read strobe, active-high.
REQ-010 Port: we  output  1  write strobe, active-high.
REQ-011 Port: halted  output  1  core stopped (only with MCPU_GEN_HALT_EN, else tied 0).

Function
REQ-012 Instruction format: opcode din[DW-1:DW-2], operand din[AW-1:0]; 00 NOR, 01 ADD, 10 STA, 11 JCC.
REQ-013 State: acc (DW bits), carry (1 bit), pc (AW), adreg (AW), FSM {FETCH, EXEC, JNT, HALT}.
REQ-014 FETCH: addr=adreg, re=1; on mem_rdy=1: pc<=adreg+1 (mod 2^AW), adreg<=operand, opcode latched.
REQ-015 FETCH next state: NOR/ADD/STA -> EXEC; JCC with carry=0 -> FETCH (taken, operand already in adreg); JCC with carry=1 -> JNT.
REQ-016 EXEC ADD: re=1; on mem_rdy: {carry,acc} <= acc+din, carry = bit DW of sum.
REQ-017 EXEC NOR: re=1; on mem_rdy: acc <= ~(acc|din); carry unchanged.
REQ-018 EXEC STA: we=1, re=0, dout=acc; on mem_rdy the write completes; acc, carry unchanged.
REQ-019 EXEC exit on mem_rdy: adreg<=pc, -> FETCH.
REQ-020 JNT: no memory cycle (re=we=0), mem_rdy ignored, carry<=0, adreg<=pc, -> FETCH; exactly one cycle.
REQ-021 Wait: in FETCH/EXEC with mem_rdy=0 all registers hold; addr, strobes, dout stable until the completing cycle.
REQ-022 re and we never both 1; both 0 in JNT, HALT and while rst=0.
REQ-023 pc wraps from 2^AW-1 to 0 without error.
REQ-024 Throughput: NOR/ADD/STA = 2 memory cycles, JCC taken = 1, JCC not taken = 2 clocks, each memory cycle stretched by mem_rdy=0 cycles.

Reset
REQ-025 rst=0 at a clock edge: acc=0, carry=0, pc=0, adreg=0, FSM=FETCH, halted=0, regardless of state or pending wait.
REQ-026 While rst=0: re=0, we=0, addr=0; first fetch from address 0 on the first edge with rst=1.

Configuration
REQ-027 Macro MCPU_GEN_HALT_EN defined: JCC fetched with carry=0 and operand equal to its own address -> HALT; halted=1, re=we=0, exit only by reset.
REQ-028 Macro undefined: no HALT state; self-jump re-fetches the same address indefinitely; halted constant 0.

Verification (DW=8)
REQ-029 Hold rst=0 2 cycles, release -> addr=0x00, re=1, we=0, dout=0x00 on first cycle.
REQ-030 acc=0xF0, instr 0x60 (ADD 0x20), mem[0x20]=0x20 -> acc=0x10, carry=1, next fetch at pc.
REQ-031 carry=1, JCC 0xC5 -> JNT one cycle, re=we=0, carry=0, next fetch at pc not 0x05; carry=0 -> next fetch at 0x05.
REQ-032 acc=0x0F, NOR 0x30 with mem=0x30 -> acc=0xC0, carry unchanged.
REQ-033 STA 0x3F with mem_rdy=0 for 3 cycles -> we=1, addr=0x3F, dout=acc stable 4 cycles, single completion; pc wrap 0x3F->0x00 checked.
REQ-034 carry=0, JCC to own address: with macro -> halted=1, re=0 next cycle; without -> re=1 repeating same addr; rst=0 mid-wait clears all.
